// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the data-cache controller.
//   - FSM state enum
//   - geometry constants (tag/index/line/word widths)
//   - CPU address field slice positions and SRAM tag-word bit positions
package dcache_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned TAG_W  = 23;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned WSEL_W = 3;
  localparam int unsigned OFF_W  = 5;

  // SRAM tag word is {valid, dirty, tag}
  localparam int unsigned STAG_W    = TAG_W + 2;
  localparam int unsigned VALID_BIT = STAG_W - 1;
  localparam int unsigned DIRTY_BIT = STAG_W - 2;

  localparam int unsigned SETS = 16;
  localparam int unsigned WAYS = 2;

  // CPU address fields
  localparam int unsigned TAG_MSB  = 31;
  localparam int unsigned TAG_LSB  = 9;
  localparam int unsigned IDX_MSB  = 8;
  localparam int unsigned IDX_LSB  = 5;
  localparam int unsigned WSEL_MSB = 4;
  localparam int unsigned WSEL_LSB = 2;

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    READMISS,
    READMISSOK
  } state_e;

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: 2-way set-associative tag/data store, 16 sets, LRU replacement.
// Lookup is combinational: on a hit tag_o/data_o show the hit way, on a miss
// they show the victim way (an invalid way first, otherwise the LRU way).
// A write goes to the hit way, or to the victim way on a miss.
// Ports:
//   clk_i, rst_i        clock, sync active-high reset (clears all tags and LRU)
//   addr_i              set index
//   tag_i               {valid, dirty, tag} to compare (tag bits) and to write
//   data_i              line to write
//   enable_i, write_i   access strobe / write strobe
//   tag_o, data_o       selected way contents
//   hit_o               tag match on a valid way
module dcache_sram
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [STAG_W-1:0] tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic [STAG_W-1:0] tag_o,
  output logic [LINE_W-1:0] data_o,
  output logic              hit_o
);

  logic [STAG_W-1:0] tag_q  [SETS][WAYS];
  logic [LINE_W-1:0] data_q [SETS][WAYS];
  logic [SETS-1:0]   lru_q;  // per set: index of the least recently used way

  logic [STAG_W-1:0] t0, t1;
  logic              hit0, hit1, victim, way_sel;

  assign t0 = tag_q[addr_i][1'b0];
  assign t1 = tag_q[addr_i][1'b1];

  // Way selection: hit way, else victim
  always_comb begin
    hit0 = t0[VALID_BIT] && (t0[TAG_W-1:0] == tag_i[TAG_W-1:0]);
    hit1 = t1[VALID_BIT] && (t1[TAG_W-1:0] == tag_i[TAG_W-1:0]);
    if (!t0[VALID_BIT])      victim = 1'b0;
    else if (!t1[VALID_BIT]) victim = 1'b1;
    else                     victim = lru_q[addr_i];
    if (hit1)      way_sel = 1'b1;
    else if (hit0) way_sel = 1'b0;
    else           way_sel = victim;
  end

  assign hit_o  = hit0 | hit1;
  assign tag_o  = tag_q[addr_i][way_sel];
  assign data_o = data_q[addr_i][way_sel];

  // Storage update; any touched way becomes MRU
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= '0;
        end
      end
      lru_q <= '0;
    end else if (enable_i) begin
      if (write_i) begin
        tag_q[addr_i][way_sel]  <= tag_i;
        data_q[addr_i][way_sel] <= data_i;
      end
      if (hit_o || write_i) lru_q[addr_i] <= ~way_sel;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: write-back, write-allocate data-cache controller in front
// of a 2-way 16-set SRAM (dcache_sram) with 256-bit lines.
// Hits complete in IDLE without stalling; a miss walks
// MISS -> [WRITEBACK] -> READMISS -> READMISSOK -> IDLE, where the latched
// request is replayed as a hit.
// Ports:
//   clk_i, rst_i                    clock, sync active-high reset
//   cpu_addr_i, cpu_data_i          CPU byte address, store data
//   cpu_MemRead_i, cpu_MemWrite_i   load / store request (both = store)
//   cpu_data_o                      load data (combinational from the hit line)
//   cpu_stall_o                     pipeline stall (combinational)
//   mem_addr_o, mem_data_o          line address / writeback line (registered)
//   mem_enable_o, mem_write_o       one-cycle memory request pulse, direction
//   mem_data_i, mem_ack_i           refill line, one-cycle completion pulse
// Optional: define DCACHE_PERF_CNT_EN to add hit_cnt_o / miss_cnt_o.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [WORD_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              replay_q, replay_d;
  logic              mem_enable_q, mem_enable_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;

  logic              use_live;
  logic [ADDR_W-1:0] eff_addr;
  logic [WORD_W-1:0] eff_wdata;
  logic              eff_wr, eff_req;
  logic [WSEL_W-1:0] wsel;
  logic [WORD_W-1:0] rd_word;
  logic [LINE_W-1:0] merged_line;
  logic              stall_c;

  logic              sram_en, sram_we, sram_hit;
  logic [STAG_W-1:0] sram_tag_i, sram_tag_o;
  logic [LINE_W-1:0] sram_wdata, sram_rdata;

  logic              unused_addr_bits;

  // Live CPU request in IDLE, latched request everywhere else (incl. replay)
  assign use_live  = (state_q == IDLE) && !replay_q;
  assign eff_addr  = use_live ? cpu_addr_i : addr_q;
  assign eff_wdata = use_live ? cpu_data_i : wdata_q;
  assign eff_wr    = use_live ? cpu_MemWrite_i : wr_q;
  assign eff_req   = use_live ? (cpu_MemRead_i | cpu_MemWrite_i) : 1'b1;
  assign wsel      = eff_addr[WSEL_MSB:WSEL_LSB];
  assign unused_addr_bits = ^eff_addr[WSEL_LSB-1:0];

  // Word select and store merge
  always_comb begin
    rd_word     = sram_rdata[WORD_W*wsel +: WORD_W];
    merged_line = sram_rdata;
    merged_line[WORD_W*wsel +: WORD_W] = eff_wdata;
  end

  dcache_sram u_sram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .addr_i   (eff_addr[IDX_MSB:IDX_LSB]),
    .tag_i    (sram_tag_i),
    .data_i   (sram_wdata),
    .enable_i (sram_en),
    .write_i  (sram_we),
    .tag_o    (sram_tag_o),
    .data_o   (sram_rdata),
    .hit_o    (sram_hit)
  );

  // Next state, memory request and SRAM control
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    replay_d     = 1'b0;
    mem_enable_d = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    sram_en      = 1'b0;
    sram_we      = 1'b0;
    sram_tag_i   = {1'b1, 1'b0, eff_addr[TAG_MSB:TAG_LSB]};
    sram_wdata   = merged_line;
    stall_c      = 1'b1;

    case (state_q)
      IDLE: begin
        stall_c = 1'b0;
        if (eff_req) begin
          if (sram_hit) begin
            sram_en    = 1'b1;
            sram_we    = eff_wr;
            sram_tag_i = {1'b1, eff_wr, eff_addr[TAG_MSB:TAG_LSB]};
          end else begin
            stall_c = 1'b1;
            addr_d  = eff_addr;
            wdata_d = eff_wdata;
            wr_d    = eff_wr;
            state_d = MISS;
          end
        end
      end
      MISS: begin
        mem_enable_d = 1'b1;
        if (sram_tag_o[VALID_BIT] && sram_tag_o[DIRTY_BIT]) begin
          mem_write_d = 1'b1;
          mem_addr_d  = {sram_tag_o[TAG_W-1:0], addr_q[IDX_MSB:IDX_LSB], {OFF_W{1'b0}}};
          mem_data_d  = sram_rdata;
          state_d     = WRITEBACK;
        end else begin
          mem_addr_d  = {addr_q[TAG_MSB:IDX_LSB], {OFF_W{1'b0}}};
          state_d     = READMISS;
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          mem_enable_d = 1'b1;
          mem_addr_d   = {addr_q[TAG_MSB:IDX_LSB], {OFF_W{1'b0}}};
          state_d      = READMISS;
        end
      end
      READMISS: begin
        if (mem_ack_i) begin
          sram_en    = 1'b1;
          sram_we    = 1'b1;
          sram_tag_i = {1'b1, 1'b0, addr_q[TAG_MSB:TAG_LSB]};
          sram_wdata = mem_data_i;
          state_d    = READMISSOK;
        end
      end
      READMISSOK: begin
        replay_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      replay_q     <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      replay_q     <= replay_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  assign cpu_stall_o  = !rst_i && stall_c;
  assign cpu_data_o   = rst_i ? '0 : rd_word;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        hit_evt, miss_evt;

  // The replay after a refill is not a new hit
  assign hit_evt  = (state_q == IDLE) && eff_req && sram_hit && !replay_q;
  assign miss_evt = (state_q == IDLE) && eff_req && !sram_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_evt) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: randomized self-checking bench for dcache_controller.
// The reference cache is a recency-ordered list of resident lines (front =
// most recent, at most two per index) over a sparse main-memory map; the
// bench also plays the memory, answering requests after a random delay.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_rd, cpu_wr, cpu_stall;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wline, mem_rline;
  logic         mem_en, mem_we, mem_ack;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt, miss_cnt;
  int           sb_hits, sb_misses;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cpu_addr_i     (cpu_addr),
    .cpu_data_i     (cpu_wdata),
    .cpu_MemRead_i  (cpu_rd),
    .cpu_MemWrite_i (cpu_wr),
    .cpu_data_o     (cpu_rdata),
    .cpu_stall_o    (cpu_stall),
    .mem_addr_o     (mem_addr),
    .mem_data_o     (mem_wline),
    .mem_enable_o   (mem_en),
    .mem_write_o    (mem_we),
    .mem_data_i     (mem_rline),
    .mem_ack_i      (mem_ack)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt_o      (hit_cnt),
    .miss_cnt_o     (miss_cnt)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]   idx;
    logic [22:0]  tag;
    logic         dirty;
    logic [255:0] data;
  } mline_t;

  mline_t       lines[$];
  logic [255:0] mem_model [logic [31:0]];

  function automatic logic [255:0] mem_get(input logic [31:0] la);
    logic [255:0] l;
    if (!mem_model.exists(la)) begin
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      mem_model[la] = l;
    end
    return mem_model[la];
  endfunction

  task automatic model_reset();
    lines.delete();
`ifdef DCACHE_PERF_CNT_EN
    sb_hits   = 0;
    sb_misses = 0;
`endif
  endtask

  task automatic model_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic hit, output int n_wb, output logic [31:0] wb_addr,
                              output logic [255:0] wb_data, output logic [31:0] rd_addr,
                              output logic [31:0] rdata);
    logic [3:0]  idx = addr[8:5];
    logic [22:0] tag = addr[31:9];
    int unsigned wi  = int'(addr[4:2]);
    int          pos = -1;
    int          cnt = 0;
    int          last = -1;
    mline_t      e;
    n_wb = 0; wb_addr = '0; wb_data = '0; rd_addr = '0;
    for (int i = 0; i < lines.size(); i++)
      if (lines[i].idx == idx && lines[i].tag == tag) pos = i;
    if (pos >= 0) begin
      hit = 1'b1;
      e = lines[pos];
      lines.delete(pos);
    end else begin
      hit = 1'b0;
      for (int i = 0; i < lines.size(); i++)
        if (lines[i].idx == idx) begin cnt++; last = i; end
      if (cnt == 2) begin
        if (lines[last].dirty) begin
          n_wb    = 1;
          wb_addr = {lines[last].tag, idx, 5'b0};
          wb_data = lines[last].data;
          mem_model[wb_addr] = wb_data;
        end
        lines.delete(last);
      end
      rd_addr = {tag, idx, 5'b0};
      e.idx = idx; e.tag = tag; e.dirty = 1'b0; e.data = mem_get(rd_addr);
    end
`ifdef DCACHE_PERF_CNT_EN
    if (hit) sb_hits++; else sb_misses++;
`endif
    if (wr) begin
      e.data[wi*32 +: 32] = wdata;
      e.dirty = 1'b1;
    end
    rdata = e.data[wi*32 +: 32];
    lines.push_front(e);
  endtask

  // ---------------- stimulus driver (CPU + memory) ----------------
  task automatic do_access(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic stalled, output int n_wb, output logic [31:0] wb_addr,
                           output logic [255:0] wb_data, output int n_rd,
                           output logic [31:0] rd_addr, output logic first_wr,
                           output logic timed_out);
    logic pending = 1'b0;
    logic pend_wr = 1'b0;
    int   dly = 0;
    logic done = 1'b0;
    logic seen = 1'b0;
    stalled = 1'b0; n_wb = 0; n_rd = 0; wb_addr = '0; wb_data = '0; rd_addr = '0;
    rdata = '0; first_wr = 1'b0;
    cpu_addr = addr; cpu_wdata = wdata; cpu_rd = rd_en; cpu_wr = wr_en;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!cpu_stall) begin
        rdata = cpu_rdata;
        done  = 1'b1;
      end else begin
        stalled = 1'b1;
        if (mem_en) begin
          if (!seen) first_wr = mem_we;
          seen = 1'b1;
          if (mem_we) begin n_wb++; wb_addr = mem_addr; wb_data = mem_wline; end
          else begin n_rd++; rd_addr = mem_addr; end
          pending = 1'b1;
          pend_wr = mem_we;
          dly = $urandom_range(0, 3);
        end
        if (pending) begin
          if (dly == 0) begin
            mem_ack   = 1'b1;
            mem_rline = pend_wr ? {8{$urandom}} : mem_get(mem_addr);
            pending   = 1'b0;
          end else dly--;
        end
      end
    end
    timed_out = !done;
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Shared per-access outputs
  logic [31:0]  o_rdata, o_wb_addr, o_rd_addr, e_wb_addr, e_rd_addr, e_rdata;
  logic [255:0] o_wb_data, e_wb_data;
  logic         o_stalled, o_first_wr, o_to, e_hit;
  int           o_nwb, o_nrd, e_nwb;

  task automatic run(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                     input logic [31:0] wdata);
    model_access(wr_en, addr, wdata, e_hit, e_nwb, e_wb_addr, e_wb_data, e_rd_addr, e_rdata);
    do_access(rd_en, wr_en, addr, wdata, o_rdata, o_stalled, o_nwb, o_wb_addr, o_wb_data,
              o_nrd, o_rd_addr, o_first_wr, o_to);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    mem_ack = 1'b0; mem_rline = '0;
    apply_reset();
    @(negedge clk);
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b expected 0", cpu_stall); end
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL reset_enable: got %b expected 0", mem_en); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_write: got %b expected 0", mem_we); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    total++; if (mem_wline !== 256'h0) begin bad++; $display("FAIL reset_mem_data: got %h expected 0", mem_wline); end
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL reset_cpu_data: got %h expected 0", cpu_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_cold_load();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    l[63:32] = 32'hDEAD_BEEF;
    mem_model[32'h0000_0200] = l;
    run(1'b1, 1'b0, 32'h0000_0204, 32'h0);
    total++; if (o_stalled !== 1'b1) begin bad++; $display("FAIL cold_stall: got %b expected 1", o_stalled); end
    total++; if (o_rd_addr !== 32'h0000_0200 || o_nrd != 1) begin bad++; $display("FAIL cold_rd_addr: got %h n=%0d expected 00000200 n=1", o_rd_addr, o_nrd); end
    total++; if (o_nwb != 0) begin bad++; $display("FAIL cold_no_wb: got %0d expected 0", o_nwb); end
    total++; if (o_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL cold_data: got %h expected deadbeef", o_rdata); end
    total++; if (o_to !== 1'b0) begin bad++; $display("FAIL cold_timeout: got %b expected 0", o_to); end
  endtask

  task automatic test_store_hit();
    run(1'b0, 1'b1, 32'h0000_0208, 32'h1234_5678);
    total++; if (o_stalled !== 1'b0) begin bad++; $display("FAIL store_hit_stall: got %b expected 0", o_stalled); end
    run(1'b1, 1'b0, 32'h0000_0208, 32'h0);
    total++; if (o_stalled !== 1'b0) begin bad++; $display("FAIL store_hit_load_stall: got %b expected 0", o_stalled); end
    total++; if (o_rdata !== 32'h1234_5678) begin bad++; $display("FAIL store_hit_load: got %h expected 12345678", o_rdata); end
  endtask

  task automatic test_dirty_evict();
    run(1'b0, 1'b1, 32'h0000_0400, $urandom);
    total++; if (o_stalled !== 1'b1 || o_nwb != 0 || o_rd_addr !== 32'h0000_0400) begin bad++; $display("FAIL fill_400: got stall=%b nwb=%0d rd=%h expected 1 0 00000400", o_stalled, o_nwb, o_rd_addr); end
    run(1'b1, 1'b0, 32'h0000_0200, 32'h0);
    total++; if (o_stalled !== 1'b0 || o_rdata !== e_rdata) begin bad++; $display("FAIL touch_200: got stall=%b data=%h expected 0 %h", o_stalled, o_rdata, e_rdata); end
    run(1'b1, 1'b0, 32'h0000_0600, 32'h0);
    total++; if (o_nwb != 1 || o_first_wr !== 1'b1) begin bad++; $display("FAIL evict_wb_first: got nwb=%0d first_wr=%b expected 1 1", o_nwb, o_first_wr); end
    total++; if (o_wb_addr !== 32'h0000_0400) begin bad++; $display("FAIL evict_wb_addr: got %h expected 00000400", o_wb_addr); end
    total++; if (o_wb_data !== e_wb_data) begin bad++; $display("FAIL evict_wb_data: got %h expected %h", o_wb_data, e_wb_data); end
    total++; if (o_nrd != 1 || o_rd_addr !== 32'h0000_0600) begin bad++; $display("FAIL evict_rd_addr: got %h n=%0d expected 00000600 n=1", o_rd_addr, o_nrd); end
    total++; if (o_rdata !== e_rdata) begin bad++; $display("FAIL evict_load: got %h expected %h", o_rdata, e_rdata); end
  endtask

  task automatic test_counters();
`ifdef DCACHE_PERF_CNT_EN
    @(negedge clk);
    total++; if (hit_cnt !== 32'(sb_hits)) begin bad++; $display("FAIL hit_cnt: got %0d expected %0d", hit_cnt, sb_hits); end
    total++; if (miss_cnt !== 32'(sb_misses)) begin bad++; $display("FAIL miss_cnt: got %0d expected %0d", miss_cnt, sb_misses); end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_clean_evict();
    run(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    run(1'b1, 1'b0, 32'h0000_0220, 32'h0);
    run(1'b1, 1'b0, 32'h0000_0420, 32'h0);
    total++; if (o_nwb != e_nwb || o_nwb != 0) begin bad++; $display("FAIL clean_no_wb: got %0d expected 0", o_nwb); end
    total++; if (o_stalled !== 1'b1 || o_rd_addr !== 32'h0000_0420) begin bad++; $display("FAIL clean_rd: got stall=%b rd=%h expected 1 00000420", o_stalled, o_rd_addr); end
    total++; if (o_rdata !== e_rdata) begin bad++; $display("FAIL clean_load: got %h expected %h", o_rdata, e_rdata); end
  endtask

  task automatic test_reset_mid_miss();
    logic seen = 1'b0;
    apply_reset();
    cpu_addr = 32'h0000_00A0; cpu_rd = 1'b1; cpu_wr = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_en) seen = 1'b1;
    end
    total++; if (!seen || mem_we !== 1'b0 || mem_addr !== 32'h0000_00A0) begin bad++; $display("FAIL rmid_readmiss: got seen=%b we=%b addr=%h expected 1 0 000000a0", seen, mem_we, mem_addr); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if ({cpu_stall, mem_en, mem_we} !== 3'b000 || mem_addr !== 32'h0 || mem_wline !== 256'h0) begin bad++; $display("FAIL rmid_outputs: got stall=%b en=%b we=%b addr=%h expected all 0", cpu_stall, mem_en, mem_we, mem_addr); end
    rst = 1'b0; cpu_rd = 1'b0;
    model_reset();
    @(negedge clk);
    mem_ack = 1'b1; mem_rline = {8{32'hBAD0_BAD0}};
    @(negedge clk);
    mem_ack = 1'b0;
    total++; if (mem_en !== 1'b0 || cpu_stall !== 1'b0) begin bad++; $display("FAIL rmid_late_ack: got en=%b stall=%b expected 0 0", mem_en, cpu_stall); end
    @(posedge clk); #1;
    run(1'b1, 1'b0, 32'h0000_00A0, 32'h0);
    total++; if (o_stalled !== 1'b1 || o_rdata !== e_rdata) begin bad++; $display("FAIL rmid_no_write: got stall=%b data=%h expected 1 %h", o_stalled, o_rdata, e_rdata); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic        r, w;
    int          op;
    for (int n = 0; n < 300; n++) begin
      a = {9'(0), 14'($urandom_range(0, 4)), 4'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'b00};
      op = $urandom_range(0, 9);
      r = (op < 5) || (op == 9);
      w = (op >= 5);
      run(r, w, a, $urandom);
      total++; if (o_to !== 1'b0 || o_stalled !== !e_hit) begin bad++; $display("FAIL rnd_hit[%0d]: addr=%h got stall=%b to=%b expected stall=%b", n, a, o_stalled, o_to, !e_hit); end
      total++; if (o_nwb != e_nwb) begin bad++; $display("FAIL rnd_wb_count[%0d]: addr=%h got %0d expected %0d", n, a, o_nwb, e_nwb); end
      if (e_nwb == 1) begin
        total++; if (o_wb_addr !== e_wb_addr || o_wb_data !== e_wb_data) begin bad++; $display("FAIL rnd_wb[%0d]: got %h expected %h", n, o_wb_addr, e_wb_addr); end
      end
      if (!e_hit) begin
        total++; if (o_nrd != 1 || o_rd_addr !== e_rd_addr) begin bad++; $display("FAIL rnd_rd[%0d]: got %h n=%0d expected %h", n, o_rd_addr, o_nrd, e_rd_addr); end
      end
      if (!w) begin
        total++; if (o_rdata !== e_rdata) begin bad++; $display("FAIL rnd_load[%0d]: addr=%h got %h expected %h", n, a, o_rdata, e_rdata); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    test_reset();
    test_cold_load();
    test_store_hit();
    test_dirty_evict();
    test_counters();
    test_clean_evict();
    test_reset_mid_miss();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
